piso_serializer: RTL and testbench

Parallel-in, serial-out transmitter that feeds the team's 8-bit serial-in shift register. It accepts a WIDTH-bit word through a valid/ready load handshake, then presents it one bit per accepted shift on serial_out, MSB first. The receiver shifts left with the new bit entering at the LSB, so after WIDTH accepted shifts it holds the original word. Wiring: serial_out to the receiver's data_in, and (serial_valid AND shift_enable) to the receiver's shift_enable.

---
 rtl/piso_serializer.sv | 107 ++++++++++
 tb/tb_piso_serializer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: accepts a WIDTH-bit word on a valid/ready
// load port and presents it MSB first, one bit per accepted shift.
module piso_serializer #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_enable,
    output logic             serial_out,
    output logic             serial_valid,
    output logic [CW-1:0]    bits_left,
    output logic             busy,
    output logic             done,
    input  logic             flush,
    output logic             fsm_state
);

    // Load handshake: a word transfers on any rising edge where load_valid and
    // load_ready are both high (and flush is low). load_ready may rise
    // combinationally from shift_enable while the last bit is being consumed.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bits_q, bits_d;
    logic             done_q, done_d;
    logic             last_bit;

    assign last_bit = (state_q == SHIFT) && (bits_q == CW'(1)) && shift_enable;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bits_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bits_q  <= bits_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bits_d     = bits_q;
        done_d     = 1'b0;
        load_ready = (state_q == IDLE) || last_bit;

        if (flush) begin
            // Abort wins over any load or shift on the same edge.
            state_d = IDLE;
            shreg_d = '0;
            bits_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        state_d = SHIFT;
                        shreg_d = load_data;
                        bits_d  = CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    if (shift_enable) begin
                        if (bits_q > CW'(1)) begin
                            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                            bits_d  = bits_q - CW'(1);
                        end else begin
                            done_d = 1'b1;
                            if (load_valid) begin
                                shreg_d = load_data;
                                bits_d  = CW'(WIDTH);
                            end else begin
                                state_d = IDLE;
                                shreg_d = '0;
                                bits_d  = '0;
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    shreg_d = '0;
                    bits_d  = '0;
                end
            endcase
        end
    end

    assign serial_valid = (state_q == SHIFT);
    assign serial_out   = (state_q == SHIFT) && shreg_q[WIDTH-1];
    assign busy         = serial_valid;
    assign bits_left    = bits_q;
    assign done         = done_q;
    assign fsm_state    = state_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer with a behavioural 8-bit receiver on the
// serial side.
module tb_piso_serializer;

    logic       clk;
    logic       reset_n;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_data;
    logic       shift_enable;
    logic       serial_out;
    logic       serial_valid;
    logic [3:0] bits_left;
    logic       busy;
    logic       done;
    logic       flush;
    logic       fsm_state;

    logic       rx_clr;
    logic [7:0] rx_data;

    int tests_run;
    int tests_failed;

    logic [15:0] exp16;
    logic [9:0]  pat;
    int          accepted;

    piso_serializer #(.WIDTH(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .shift_enable (shift_enable),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .bits_left    (bits_left),
        .busy         (busy),
        .done         (done),
        .flush        (flush),
        .fsm_state    (fsm_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Receiver: shifts left, new bit into the LSB, when the transmitter's bit is accepted.
    always_ff @(posedge clk) begin
        if (rx_clr)
            rx_data <= 8'h00;
        else if (serial_valid && shift_enable)
            rx_data <= {rx_data[6:0], serial_out};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [7:0] d);
        load_valid = 1'b1;
        load_data  = d;
        #1;
        chk("load_ready_idle", {31'b0, load_ready}, 32'd1);
        tick();
        load_valid = 1'b0;
    endtask

    task automatic run_shift(input logic [7:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            shift_enable = 1'b1;
            chk("serial_valid", {31'b0, serial_valid}, 32'd1);
            chk("serial_out", {31'b0, serial_out}, {31'b0, w[7-i]});
            chk("bits_left", {28'b0, bits_left}, 32'(8 - i));
            chk("done_mid", {31'b0, done}, 32'd0);
            tick();
        end
        shift_enable = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        load_valid   = 1'b0;
        load_data    = 8'h00;
        shift_enable = 1'b0;
        flush        = 1'b0;
        rx_clr       = 1'b1;

        // Reset state
        #2;
        chk("rst_serial_valid", {31'b0, serial_valid}, 32'd0);
        chk("rst_serial_out", {31'b0, serial_out}, 32'd0);
        chk("rst_bits_left", {28'b0, bits_left}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_state", {31'b0, fsm_state}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        rx_clr = 1'b0;

        // 1: A5 with continuous shift -> 1,0,1,0,0,1,0,1
        load_word(8'hA5);
        run_shift(8'b1010_0101, 8);
        chk("t1_done", {31'b0, done}, 32'd1);
        chk("t1_load_ready", {31'b0, load_ready}, 32'd1);
        chk("t1_idle", {31'b0, serial_valid}, 32'd0);
        chk("t1_bits_zero", {28'b0, bits_left}, 32'd0);
        tick();
        chk("t1_done_once", {31'b0, done}, 32'd0);

        // 2: 3C into the receiver with stalls
        rx_clr = 1'b1;
        load_word(8'h3C);
        rx_clr   = 1'b0;
        pat      = 10'b10_1101_1111;
        exp16    = {8'h3C, 8'h00};
        accepted = 0;
        for (int k = 0; k < 10; k++) begin
            shift_enable = pat[9-k];
            chk("t2_serial_out", {31'b0, serial_out}, {31'b0, exp16[15-accepted]});
            chk("t2_bits_left", {28'b0, bits_left}, 32'(8 - accepted));
            if (pat[9-k]) accepted++;
            tick();
        end
        shift_enable = 1'b0;
        chk("t2_rx_data", {24'b0, rx_data}, 32'h3C);
        chk("t2_done", {31'b0, done}, 32'd1);
        tick();

        // 3: back-to-back F0 then 0F, no gap
        load_word(8'hF0);
        exp16 = 16'b1111_0000_0000_1111;
        for (int i = 0; i < 16; i++) begin
            shift_enable = 1'b1;
            load_valid   = (i == 7);
            load_data    = 8'h0F;
            #1;
            chk("t3_serial_valid", {31'b0, serial_valid}, 32'd1);
            chk("t3_serial_out", {31'b0, serial_out}, {31'b0, exp16[15-i]});
            chk("t3_done", {31'b0, done}, {31'b0, (i == 8)});
            if (i == 7 || i == 15)
                chk("t3_ready_last", {31'b0, load_ready}, 32'd1);
            else
                chk("t3_ready_busy", {31'b0, load_ready}, 32'd0);
            tick();
        end
        load_valid   = 1'b0;
        shift_enable = 1'b0;
        chk("t3_done2", {31'b0, done}, 32'd1);
        chk("t3_idle", {31'b0, serial_valid}, 32'd0);
        tick();

        // 4: 81 with an ignored load at bits_left=5
        load_word(8'h81);
        exp16 = {8'h81, 8'h00};
        for (int i = 0; i < 8; i++) begin
            shift_enable = 1'b1;
            load_valid   = (i == 3);
            load_data    = 8'hFF;
            #1;
            if (i == 3) begin
                chk("t4_bits5", {28'b0, bits_left}, 32'd5);
                chk("t4_ready_low", {31'b0, load_ready}, 32'd0);
            end
            chk("t4_serial_out", {31'b0, serial_out}, {31'b0, exp16[15-i]});
            tick();
        end
        load_valid   = 1'b0;
        shift_enable = 1'b0;
        chk("t4_done", {31'b0, done}, 32'd1);
        tick();

        // 5: AA, 3 bits, then async reset between edges
        load_word(8'hAA);
        run_shift(8'hAA, 3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_serial_valid", {31'b0, serial_valid}, 32'd0);
        chk("t5_busy", {31'b0, busy}, 32'd0);
        chk("t5_bits_left", {28'b0, bits_left}, 32'd0);
        chk("t5_serial_out", {31'b0, serial_out}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("t5_no_done", {31'b0, done}, 32'd0);
        load_word(8'h55);
        run_shift(8'b0101_0101, 8);
        chk("t5_done_55", {31'b0, done}, 32'd1);
        tick();

        // 6: C3, 4 bits, flush
        rx_clr = 1'b1;
        load_word(8'hC3);
        rx_clr = 1'b0;
        run_shift(8'hC3, 4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t6_serial_valid", {31'b0, serial_valid}, 32'd0);
        chk("t6_bits_left", {28'b0, bits_left}, 32'd0);
        chk("t6_done", {31'b0, done}, 32'd0);
        chk("t6_state", {31'b0, fsm_state}, 32'd0);
        chk("t6_rx_data", {24'b0, rx_data}, 32'h0C);
        tick();
        chk("t6_done_late", {31'b0, done}, 32'd0);

        // Load on the same edge as flush is discarded
        flush      = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'hE7;
        #1;
        chk("flush_ready", {31'b0, load_ready}, 32'd1);
        tick();
        flush      = 1'b0;
        load_valid = 1'b0;
        chk("flush_load_drop", {31'b0, serial_valid}, 32'd0);
        chk("flush_load_bits", {28'b0, bits_left}, 32'd0);

        // shift_enable in IDLE is ignored
        shift_enable = 1'b1;
        tick();
        shift_enable = 1'b0;
        chk("idle_shift", {31'b0, serial_valid}, 32'd0);
        chk("idle_done", {31'b0, done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
